// File: rtl/riscv_csr_file.sv
// riscv_csr_file
// Machine-mode CSR file for the execute stage. It holds the trap-handling
// CSRs (mstatus, mie, mip, mtvec, mscratch, mepc, mcause, mtval), the 64-bit
// mcycle/minstret counters, NUM_HPM event counters and mcountinhibit. It also
// resolves the trap and mret side effects and arbitrates pending interrupts.
//
// Ports:
//   clk_i, rst_i             clock, asynchronous active-high reset
//   csr_en_i, csr_we_i       CSR access valid / access intends a write
//   opcode_i, addr_i, din_i  read-modify-write op, CSR address, operand
//   dout_o, illegal_o        pre-update read data (0 if illegal), illegal flag
//   trap_i, mcause_i,        trap taken this cycle with its cause, value and
//   mtval_i, pc_i            faulting PC
//   mret_i                   mret retiring this cycle
//   instret_i, hpm_event_i   counter increment events
//   irq_i                    {external, timer, software} level interrupts
//   trap_pc_o, mepc_o        trap handler target, mret target
//   irq_req_o, irq_cause_o   enabled interrupt pending and its cause
//
// Access qualification: an access happens in any cycle with csr_en_i high.
// Its state change lands on the next rising edge only when csr_we_i is also
// high and the access is legal; dout_o always shows the value before that edge.

module riscv_csr_file #(
    parameter int unsigned MXLEN          = 32,
    parameter int unsigned NUM_HPM        = 2,
    parameter logic [31:0] MTVEC_RESET    = 32'h0000_0000,
    parameter bit          VECTORED_EN    = 1'b1,
    parameter int unsigned CSR_OP_WIDTH   = 2,
    parameter int unsigned CSR_ADDR_WIDTH = 12
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      csr_en_i,
    input  logic                      csr_we_i,
    input  logic [CSR_OP_WIDTH-1:0]   opcode_i,
    input  logic [CSR_ADDR_WIDTH-1:0] addr_i,
    input  logic [MXLEN-1:0]          din_i,
    output logic [MXLEN-1:0]          dout_o,
    output logic                      illegal_o,
    input  logic                      trap_i,
    input  logic [MXLEN-1:0]          mcause_i,
    input  logic [MXLEN-1:0]          mtval_i,
    input  logic [MXLEN-1:0]          pc_i,
    input  logic                      mret_i,
    input  logic                      instret_i,
    input  logic [NUM_HPM-1:0]        hpm_event_i,
    input  logic [2:0]                irq_i,
    output logic [MXLEN-1:0]          trap_pc_o,
    output logic [MXLEN-1:0]          mepc_o,
    output logic                      irq_req_o,
    output logic [MXLEN-1:0]          irq_cause_o
);

    localparam logic [CSR_OP_WIDTH-1:0] CSR_OP_CURR = CSR_OP_WIDTH'(0);
    localparam logic [CSR_OP_WIDTH-1:0] CSR_OP_NEXT = CSR_OP_WIDTH'(1);
    localparam logic [CSR_OP_WIDTH-1:0] CSR_OP_NAND = CSR_OP_WIDTH'(2);
    localparam logic [CSR_OP_WIDTH-1:0] CSR_OP_OR   = CSR_OP_WIDTH'(3);

    // mtvec bit1 is reserved; bit0 (vectored mode) only exists if enabled.
    localparam logic [MXLEN-1:0] MTVEC_WMASK = VECTORED_EN ? ~32'h2 : ~32'h3;
    localparam logic [MXLEN-1:0] MIE_WMASK   = 32'h0000_0888;
    // CY (bit0), IR (bit2) and one bit per implemented HPM counter.
    localparam logic [MXLEN-1:0] MCI_WMASK   = 32'h5 | (((32'd1 << NUM_HPM) - 32'd1) << 3);

    function automatic logic [MXLEN-1:0] mrw(input logic [CSR_OP_WIDTH-1:0] op,
                                             input logic [MXLEN-1:0]        cur,
                                             input logic [MXLEN-1:0]        din);
        case (op)
            CSR_OP_NEXT: return din;
            CSR_OP_NAND: return cur & ~din;
            CSR_OP_OR:   return cur | din;
            default:     return cur;
        endcase
    endfunction

    logic             mstatus_mie_q, mstatus_mpie_q;
    logic [MXLEN-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
    logic [MXLEN-1:0] mcountinhibit_q;
    logic [2:0]       mip_q;
    logic [63:0]      mcycle_q, minstret_q, mcycle_d, minstret_d;
    logic [63:0]      hpm_q [NUM_HPM];
    logic [63:0]      hpm_d [NUM_HPM];

    logic [MXLEN-1:0] mstatus_rd, mip_rd, rdata, wdata, pend, mtvec_base;
    logic             hit, wr_en;
    logic             wr_mstatus, wr_mie, wr_mtvec, wr_mscratch, wr_mepc;
    logic             wr_mcause, wr_mtval, wr_mcountinhibit;
    logic             wr_mcycle, wr_mcycleh, wr_minstret, wr_minstreth;
    logic [4:0]       irq_code;

    always_comb begin
        mstatus_rd        = '0;
        mstatus_rd[12:11] = 2'b11;
        mstatus_rd[7]     = mstatus_mpie_q;
        mstatus_rd[3]     = mstatus_mie_q;
        mip_rd            = '0;
        mip_rd[11]        = mip_q[2];
        mip_rd[7]         = mip_q[1];
        mip_rd[3]         = mip_q[0];
    end

    // Read decode; hit doubles as the "address implemented" flag.
    always_comb begin
        hit   = 1'b1;
        rdata = '0;
        case (addr_i)
            12'h300: rdata = mstatus_rd;
            12'h304: rdata = mie_q;
            12'h305: rdata = mtvec_q;
            12'h340: rdata = mscratch_q;
            12'h341: rdata = mepc_q;
            12'h342: rdata = mcause_q;
            12'h343: rdata = mtval_q;
            12'h344: rdata = mip_rd;
            12'h320: rdata = mcountinhibit_q;
            12'hB00, 12'hC00: rdata = mcycle_q[31:0];
            12'hB80, 12'hC80: rdata = mcycle_q[63:32];
            12'hB02, 12'hC02: rdata = minstret_q[31:0];
            12'hB82, 12'hC82: rdata = minstret_q[63:32];
            default: hit = 1'b0;
        endcase
        for (int i = 0; i < NUM_HPM; i++) begin
            if (addr_i == CSR_ADDR_WIDTH'(32'hB03 + i)) begin
                hit   = 1'b1;
                rdata = hpm_q[i][31:0];
            end
            if (addr_i == CSR_ADDR_WIDTH'(32'hB83 + i)) begin
                hit   = 1'b1;
                rdata = hpm_q[i][63:32];
            end
        end
    end

    // Addresses with [11:10]==2'b11 are read-only; writing them is illegal.
    assign illegal_o = csr_en_i & (~hit | (csr_we_i & (addr_i[11:10] == 2'b11)));
    assign dout_o    = illegal_o ? '0 : rdata;
    assign wdata     = mrw(opcode_i, rdata, din_i);
    assign wr_en     = csr_en_i & csr_we_i & ~illegal_o;

    assign wr_mstatus       = wr_en & (addr_i == 12'h300);
    assign wr_mie           = wr_en & (addr_i == 12'h304);
    assign wr_mtvec         = wr_en & (addr_i == 12'h305);
    assign wr_mscratch      = wr_en & (addr_i == 12'h340);
    assign wr_mepc          = wr_en & (addr_i == 12'h341);
    assign wr_mcause        = wr_en & (addr_i == 12'h342);
    assign wr_mtval         = wr_en & (addr_i == 12'h343);
    assign wr_mcountinhibit = wr_en & (addr_i == 12'h320);
    assign wr_mcycle        = wr_en & (addr_i == 12'hB00);
    assign wr_mcycleh       = wr_en & (addr_i == 12'hB80);
    assign wr_minstret      = wr_en & (addr_i == 12'hB02);
    assign wr_minstreth     = wr_en & (addr_i == 12'hB82);

    // Each counter first takes its normal increment; a CSR write then replaces
    // just the addressed half, so a written low half does not carry that cycle.
    always_comb begin
        mcycle_d = mcycle_q + {63'd0, ~mcountinhibit_q[0]};
        if (wr_mcycle)  mcycle_d[31:0]  = wdata;
        if (wr_mcycleh) mcycle_d[63:32] = wdata;
        minstret_d = minstret_q + {63'd0, instret_i & ~mcountinhibit_q[2]};
        if (wr_minstret)  minstret_d[31:0]  = wdata;
        if (wr_minstreth) minstret_d[63:32] = wdata;
        for (int i = 0; i < NUM_HPM; i++) begin
            hpm_d[i] = hpm_q[i] + {63'd0, hpm_event_i[i] & ~mcountinhibit_q[3+i]};
            if (wr_en && addr_i == CSR_ADDR_WIDTH'(32'hB03 + i)) hpm_d[i][31:0]  = wdata;
            if (wr_en && addr_i == CSR_ADDR_WIDTH'(32'hB83 + i)) hpm_d[i][63:32] = wdata;
        end
    end

    // Interrupt priority: external (11) > software (3) > timer (7).
    assign pend      = mip_rd & mie_q;
    assign irq_req_o = mstatus_mie_q & (|pend);

    always_comb begin
        irq_code = 5'd0;
        if (pend[11])     irq_code = 5'd11;
        else if (pend[3]) irq_code = 5'd3;
        else if (pend[7]) irq_code = 5'd7;
        irq_cause_o = '0;
        if (irq_req_o) begin
            irq_cause_o[MXLEN-1] = 1'b1;
            irq_cause_o[4:0]     = irq_code;
        end
    end

    // Vectoring applies only to interrupt causes; exceptions go to the base.
    assign mtvec_base = {mtvec_q[MXLEN-1:2], 2'b00};
    assign trap_pc_o  = (mtvec_q[0] && mcause_i[MXLEN-1])
                      ? mtvec_base + {{(MXLEN-7){1'b0}}, mcause_i[4:0], 2'b00}
                      : mtvec_base;
    assign mepc_o     = mepc_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mstatus_mie_q   <= 1'b0;
            mstatus_mpie_q  <= 1'b0;
            mie_q           <= '0;
            mtvec_q         <= MTVEC_RESET & MTVEC_WMASK;
            mscratch_q      <= '0;
            mepc_q          <= '0;
            mcause_q        <= '0;
            mtval_q         <= '0;
            mcountinhibit_q <= '0;
            mip_q           <= '0;
            mcycle_q        <= '0;
            minstret_q      <= '0;
            for (int i = 0; i < NUM_HPM; i++) hpm_q[i] <= '0;
        end else begin
            mip_q      <= irq_i;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
            for (int i = 0; i < NUM_HPM; i++) hpm_q[i] <= hpm_d[i];

            if (wr_mie)           mie_q           <= wdata & MIE_WMASK;
            if (wr_mtvec)         mtvec_q         <= wdata & MTVEC_WMASK;
            if (wr_mscratch)      mscratch_q      <= wdata;
            if (wr_mcountinhibit) mcountinhibit_q <= wdata & MCI_WMASK;

            // Trap beats mret beats CSR write on every register they share.
            if (trap_i) begin
                mepc_q         <= pc_i & ~32'h3;
                mcause_q       <= mcause_i;
                mtval_q        <= mtval_i;
                mstatus_mpie_q <= mstatus_mie_q;
                mstatus_mie_q  <= 1'b0;
            end else begin
                if (wr_mepc)   mepc_q   <= wdata & ~32'h3;
                if (wr_mcause) mcause_q <= wdata;
                if (wr_mtval)  mtval_q  <= wdata;
                if (mret_i) begin
                    mstatus_mie_q  <= mstatus_mpie_q;
                    mstatus_mpie_q <= 1'b1;
                end else if (wr_mstatus) begin
                    mstatus_mie_q  <= wdata[3];
                    mstatus_mpie_q <= wdata[7];
                end
            end
        end
    end

endmodule

// File: tb/tb_riscv_csr_file.sv
module tb_riscv_csr_file;

  localparam int NUM_HPM = 2;
  localparam logic [1:0] OP_CURR = 2'd0;
  localparam logic [1:0] OP_NEXT = 2'd1;
  localparam logic [1:0] OP_NAND = 2'd2;
  localparam logic [1:0] OP_OR   = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic               en, we, trap, mret, instret;
  logic [1:0]         op;
  logic [11:0]        addr;
  logic [31:0]        din, mcause, mtval, pc;
  logic [NUM_HPM-1:0] hpm_ev;
  logic [2:0]         irq;

  logic [31:0] dout, trap_pc, mepc, irq_cause;
  logic        illegal, irq_req;
  logic [31:0] nv_dout, nv_trap_pc, nv_mepc, nv_irq_cause;
  logic        nv_illegal, nv_irq_req;

  riscv_csr_file #(.MXLEN(32), .NUM_HPM(NUM_HPM), .MTVEC_RESET(32'h0), .VECTORED_EN(1'b1)) u_dut (
    .clk_i(clk), .rst_i(rst), .csr_en_i(en), .csr_we_i(we), .opcode_i(op), .addr_i(addr),
    .din_i(din), .dout_o(dout), .illegal_o(illegal), .trap_i(trap), .mcause_i(mcause),
    .mtval_i(mtval), .pc_i(pc), .mret_i(mret), .instret_i(instret), .hpm_event_i(hpm_ev),
    .irq_i(irq), .trap_pc_o(trap_pc), .mepc_o(mepc), .irq_req_o(irq_req), .irq_cause_o(irq_cause)
  );

  // Same stimulus, vectored mode disabled: only its trap target is checked.
  riscv_csr_file #(.MXLEN(32), .NUM_HPM(NUM_HPM), .MTVEC_RESET(32'h0), .VECTORED_EN(1'b0)) u_dut_nv (
    .clk_i(clk), .rst_i(rst), .csr_en_i(en), .csr_we_i(we), .opcode_i(op), .addr_i(addr),
    .din_i(din), .dout_o(nv_dout), .illegal_o(nv_illegal), .trap_i(trap), .mcause_i(mcause),
    .mtval_i(mtval), .pc_i(pc), .mret_i(mret), .instret_i(instret), .hpm_event_i(hpm_ev),
    .irq_i(irq), .trap_pc_o(nv_trap_pc), .mepc_o(nv_mepc), .irq_req_o(nv_irq_req), .irq_cause_o(nv_irq_cause)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Architectural view: counters indexed by counter number n (0 cycle,
  // 2 instret, 3.. hpm), each a plain 64-bit integer.
  bit          m_mie, m_mpie;
  logic [31:0] m_mie_reg, m_mtvec, m_mtvec_nv, m_scratch, m_mepc, m_mcause, m_mtval, m_mci;
  logic [31:0] mci_mask;
  logic [2:0]  m_irq_prev;
  logic [63:0] m_cnt [32];

  function automatic bit m_cnt_exists(input int n);
    return (n == 0) || (n == 2) || (n >= 3 && n < 3 + NUM_HPM);
  endfunction

  function automatic logic [31:0] m_mip();
    logic [31:0] r;
    r = 32'h0;
    r[11] = m_irq_prev[2];
    r[7]  = m_irq_prev[1];
    r[3]  = m_irq_prev[0];
    return r;
  endfunction

  function automatic logic [31:0] m_rmw(input logic [1:0] o, input logic [31:0] cur, input logic [31:0] d);
    if (o == OP_NEXT) return d;
    if (o == OP_NAND) return cur & ~d;
    if (o == OP_OR)   return cur | d;
    return cur;
  endfunction

  function automatic void m_read(input logic [11:0] a, output logic [31:0] v, output bit ok);
    int n;
    v = 32'h0;
    ok = 1'b1;
    if (a >= 12'hB00 && a <= 12'hB1F) begin
      n = int'(a) - 'hB00;
      ok = m_cnt_exists(n);
      v = m_cnt[n][31:0];
    end else if (a >= 12'hB80 && a <= 12'hB9F) begin
      n = int'(a) - 'hB80;
      ok = m_cnt_exists(n);
      v = m_cnt[n][63:32];
    end else begin
      case (a)
        12'h300: v = 32'h1800 | (m_mpie ? 32'h80 : 32'h0) | (m_mie ? 32'h8 : 32'h0);
        12'h304: v = m_mie_reg;
        12'h305: v = m_mtvec;
        12'h340: v = m_scratch;
        12'h341: v = m_mepc;
        12'h342: v = m_mcause;
        12'h343: v = m_mtval;
        12'h344: v = m_mip();
        12'h320: v = m_mci;
        12'hC00: v = m_cnt[0][31:0];
        12'hC80: v = m_cnt[0][63:32];
        12'hC02: v = m_cnt[2][31:0];
        12'hC82: v = m_cnt[2][63:32];
        default: ok = 1'b0;
      endcase
    end
    if (!ok) v = 32'h0;
  endfunction

  function automatic void model_reset();
    m_mie = 0; m_mpie = 0;
    m_mie_reg = 0; m_mtvec = 0; m_mtvec_nv = 0; m_scratch = 0;
    m_mepc = 0; m_mcause = 0; m_mtval = 0; m_mci = 0; m_irq_prev = 0;
    for (int n = 0; n < 32; n++) m_cnt[n] = 64'h0;
  endfunction

  // Expected combinational outputs for the current model state and inputs.
  task automatic check_outputs();
    logic [31:0] v, base, exp_tpc, pend, cause;
    bit ok, ill, req;
    m_read(addr, v, ok);
    ill = en && (!ok || (we && addr[11:10] == 2'b11));
    chk("illegal", {31'h0, illegal}, {31'h0, ill});
    if (en) chk("dout", dout, ill ? 32'h0 : v);
    base = m_mtvec & ~32'h3;
    exp_tpc = (m_mtvec[0] && mcause[31]) ? base + 32'(mcause[4:0]) * 4 : base;
    chk("trap_pc", trap_pc, exp_tpc);
    chk("trap_pc_nv", nv_trap_pc, m_mtvec_nv);
    chk("mepc", mepc, m_mepc);
    pend = m_mip() & m_mie_reg;
    req = m_mie && (pend != 0);
    cause = 32'h0;
    if (req) cause = pend[11] ? 32'h8000_000B : (pend[3] ? 32'h8000_0003 : 32'h8000_0007);
    chk("irq_req", {31'h0, irq_req}, {31'h0, req});
    chk("irq_cause", irq_cause, cause);
  endtask

  // State change caused by one rising edge with the current inputs.
  function automatic void model_update();
    logic [31:0] cur, wv, wv_nv;
    logic [63:0] nc;
    bit ok, ill, wr, ev;
    m_read(addr, cur, ok);
    ill = en && (!ok || (we && addr[11:10] == 2'b11));
    wr = en && we && !ill;
    wv = m_rmw(op, cur, din);
    wv_nv = m_rmw(op, m_mtvec_nv, din);
    for (int n = 0; n < 32; n++) begin
      if (m_cnt_exists(n)) begin
        if (n == 0) ev = 1'b1;
        else if (n == 2) ev = instret;
        else ev = hpm_ev[n-3];
        nc = m_cnt[n] + ((ev && !m_mci[n]) ? 64'd1 : 64'd0);
        if (wr && addr == 12'(12'hB00 + n)) nc[31:0] = wv;
        if (wr && addr == 12'(12'hB80 + n)) nc[63:32] = wv;
        m_cnt[n] = nc;
      end
    end
    m_irq_prev = irq;
    if (wr && addr == 12'h304) m_mie_reg = wv & 32'h888;
    if (wr && addr == 12'h305) begin
      m_mtvec = wv & ~32'h2;
      m_mtvec_nv = wv_nv & ~32'h3;
    end
    if (wr && addr == 12'h340) m_scratch = wv;
    if (wr && addr == 12'h320) m_mci = wv & mci_mask;
    if (trap) begin
      m_mepc = pc & ~32'h3;
      m_mcause = mcause;
      m_mtval = mtval;
      m_mpie = m_mie;
      m_mie = 0;
    end else begin
      if (wr && addr == 12'h341) m_mepc = wv & ~32'h3;
      if (wr && addr == 12'h342) m_mcause = wv;
      if (wr && addr == 12'h343) m_mtval = wv;
      if (mret) begin
        m_mie = m_mpie;
        m_mpie = 1;
      end else if (wr && addr == 12'h300) begin
        m_mie = wv[3];
        m_mpie = wv[7];
      end
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic settle();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic advance();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    settle();
    advance();
  endtask

  task automatic set_idle();
    en = 0; we = 0; op = OP_CURR; addr = 12'h0; din = 0;
    trap = 0; mret = 0; instret = 0; hpm_ev = '0;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] v);
    en = 1; we = 1; op = OP_NEXT; addr = a; din = v;
    tick();
    set_idle();
  endtask

  task automatic csr_read_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
    en = 1; we = 0; op = OP_CURR; addr = a; din = 0;
    settle();
    chk(tag, dout, exp);
    advance();
    set_idle();
  endtask

  task automatic csr_read(input logic [11:0] a);
    en = 1; we = 0; op = OP_CURR; addr = a; din = 0;
    tick();
    set_idle();
  endtask

  logic [11:0] addr_tab [28] = '{
    12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
    12'h320, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hB03, 12'hB83, 12'hB04,
    12'hB84, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'h7C0, 12'hB01, 12'hB05,
    12'hC01, 12'hC03, 12'h301, 12'h3FF
  };

  // ---------------- directed and random sequence ----------------
  initial begin
    mci_mask = 32'h5;
    for (int i = 0; i < NUM_HPM; i++) mci_mask[3+i] = 1'b1;
    set_idle();
    irq = 0; mcause = 0; mtval = 0; pc = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    model_reset();

    // Reset values.
    en = 1; we = 0; op = OP_CURR; addr = 12'h300;
    settle();
    chk("rst_mstatus", dout, 32'h1800);
    chk("rst_irq_req", {31'h0, irq_req}, 32'h0);
    chk("rst_irq_cause", irq_cause, 32'h0);
    chk("rst_mepc", mepc, 32'h0);
    chk("rst_trap_pc", trap_pc, 32'h0);
    advance();
    set_idle();
    csr_read_chk("rst_mtvec", 12'h305, 32'h0);
    repeat (3) csr_read(12'hB00);

    // Vectored trap target.
    csr_write(12'h305, 32'h8000_0001);
    mcause = 32'h8000_0007;
    settle();
    chk("vec_trap_pc", trap_pc, 32'h8000_001C);
    chk("novec_trap_pc", nv_trap_pc, 32'h8000_0000);
    advance();
    mcause = 32'h0000_0007;
    settle();
    chk("exc_trap_pc", trap_pc, 32'h8000_0000);
    advance();
    mcause = 0;

    // Trap / mret stacking.
    csr_write(12'h300, 32'h8);
    trap = 1; pc = 32'h104; mcause = 32'h2; mtval = 32'hDEAD;
    tick();
    trap = 0;
    csr_read_chk("trap_mstatus", 12'h300, 32'h1880);
    chk("trap_mepc", mepc, 32'h104);
    csr_read_chk("trap_mcause", 12'h342, 32'h2);
    csr_read_chk("trap_mtval", 12'h343, 32'hDEAD);
    mret = 1;
    tick();
    mret = 0;
    csr_read_chk("mret_mstatus", 12'h300, 32'h1888);
    trap = 1; mret = 1; pc = 32'h207;
    tick();
    trap = 0; mret = 0;
    csr_read_chk("trapmret_mstatus", 12'h300, 32'h1880);
    chk("trapmret_mepc", mepc, 32'h204);

    // Interrupt arbitration.
    csr_write(12'h304, 32'h888);
    irq = 3'b111;
    csr_write(12'h300, 32'h8);
    settle();
    chk("irq_req_all", {31'h0, irq_req}, 32'h1);
    chk("irq_cause_ext", irq_cause, 32'h8000_000B);
    irq = 3'b011;
    advance();
    settle();
    chk("irq_cause_sw", irq_cause, 32'h8000_0003);
    irq = 3'b000;
    advance();
    tick();

    // Counter half writes, inhibit and 64-bit wrap.
    csr_write(12'hB80, 32'h0);
    csr_write(12'hB00, 32'hFFFF_FFFF);
    csr_read(12'hB80);
    csr_read_chk("mcycleh_carry", 12'hB80, 32'h1);
    csr_write(12'h320, 32'h1);
    csr_read_chk("mcycle_frozen0", 12'hB00, 32'h2);
    csr_read_chk("mcycle_frozen1", 12'hB00, 32'h2);
    csr_write(12'h320, 32'h0);
    csr_write(12'hB80, 32'hFFFF_FFFF);
    csr_write(12'hB00, 32'hFFFF_FFFF);
    csr_read(12'hB80);
    csr_read_chk("mcycleh_wrap", 12'hB80, 32'h0);
    csr_read_chk("mcycle_wrap", 12'hB00, 32'h1);

    // Illegal accesses.
    en = 1; we = 1; op = OP_NEXT; addr = 12'hC00; din = 32'h5;
    settle();
    chk("ill_wr_c00", {31'h0, illegal}, 32'h1);
    chk("ill_wr_c00_dout", dout, 32'h0);
    advance();
    en = 1; we = 0; op = OP_CURR; addr = 12'h7C0;
    settle();
    chk("ill_rd_7c0", {31'h0, illegal}, 32'h1);
    chk("ill_rd_7c0_dout", dout, 32'h0);
    advance();
    set_idle();
    csr_write(12'h340, 32'hA5A5_5A5A);
    csr_read_chk("mscratch", 12'h340, 32'hA5A5_5A5A);

    // Randomized traffic against the model.
    for (int k = 0; k < 800; k++) begin
      en      = ($urandom_range(0, 3) != 0);
      we      = 1'($urandom_range(0, 1));
      op      = 2'($urandom_range(0, 3));
      addr    = addr_tab[$urandom_range(0, 27)];
      din     = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      trap    = ($urandom_range(0, 15) == 0);
      mret    = ($urandom_range(0, 15) == 0);
      mcause  = $urandom & 32'h8000_001F;
      mtval   = $urandom;
      pc      = $urandom;
      instret = 1'($urandom_range(0, 1));
      hpm_ev  = NUM_HPM'($urandom_range(0, 3));
      irq     = 3'($urandom_range(0, 7));
      tick();
    end
    set_idle();
    irq = 0;

    // Asynchronous reset in the middle of a cycle.
    csr_write(12'h320, 32'h0);
    trap = 1; pc = 32'h400;
    tick();
    trap = 0;
    csr_write(12'h304, 32'h888);
    csr_write(12'h300, 32'h8);
    irq = 3'b001;
    tick();
    en = 1; we = 0; op = OP_CURR; addr = 12'hB00;
    settle();
    chk("pre_rst_irq_req", {31'h0, irq_req}, 32'h1);
    chk("pre_rst_mepc", mepc, 32'h400);
    advance();
    #3 rst = 1;
    #1;
    chk("async_rst_mcycle", dout, 32'h0);
    chk("async_rst_mepc", mepc, 32'h0);
    chk("async_rst_irq_req", {31'h0, irq_req}, 32'h0);
    chk("async_rst_irq_cause", irq_cause, 32'h0);
    chk("async_rst_trap_pc", trap_pc, 32'h0);
    model_reset();
    @(posedge clk);
    #1 rst = 0;
    set_idle();
    csr_read_chk("post_rst_mstatus", 12'h300, 32'h1800);
    repeat (4) csr_read(12'hB00);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_csr_file.md
# riscv_csr_file

Parametrised machine-mode CSR file for the RISC-V core: generalised successor of the single-cycle CSR block, adding mstatus interrupt-enable stacking, mip/mie interrupt arbitration, mtval, mret handling, vectored mtvec, writable 64-bit mcycle/minstret, NUM_HPM event counters with mcountinhibit, and illegal-access detection. Sits in the execute stage beside the ALU; the trap/mret controller drives its event inputs and consumes its trap/return targets and interrupt request.

## Interface
- MXLEN, 32: CSR data width (32 only; counters split into low/high halves).
- NUM_HPM, 2: hardware performance counters mhpmcounter3..3+NUM_HPM-1 (0..29).
- MTVEC_RESET, 32'h0000_0000: mtvec reset value.
- VECTORED_EN, 1: 1 allows mtvec.MODE=1 (vectored); 0 forces MODE to 0.
- clk_i  in  1  core clock, all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- csr_en_i  in  1  CSR instruction valid this cycle.
- csr_we_i  in  1  instruction intends a write (low for CSRRS/CSRRC with zero source).
- opcode_i  in  CSR_OP_WIDTH  CSR_OP_CURR / NEXT (write) / NAND (clear) / OR (set).
- addr_i  in  CSR_ADDR_WIDTH  CSR address.
- din_i  in  MXLEN  write operand.
- dout_o  out  MXLEN  read data (pre-update value).
- illegal_o  out  1  access is illegal; no state change.
- trap_i  in  1  trap taken this cycle.
- mcause_i  in  MXLEN  cause to record on trap.
- mtval_i  in  MXLEN  trap value to record on trap.
- pc_i  in  MXLEN  PC of trapping instruction.
- mret_i  in  1  mret retiring this cycle.
- instret_i  in  1  one instruction retired this cycle.
- hpm_event_i  in  NUM_HPM  per-counter increment event.
- irq_i  in  3  {external, timer, software} interrupt lines, level.
- trap_pc_o  out  MXLEN  handler target for the cause on mcause_i.
- mepc_o  out  MXLEN  mret target.
- irq_req_o  out  1  enabled interrupt pending.
- irq_cause_o  out  MXLEN  cause of highest-priority pending interrupt.

## Operation
- Implemented CSRs: mstatus 0x300 (MIE bit3, MPIE bit7, MPP[12:11] hardwired 2'b11, others 0), mie 0x304 (bits 3/7/11 writable, others 0), mtvec 0x305, mscratch 0x340, mepc 0x341 (bits[1:0] read 0), mcause 0x342, mtval 0x343, mip 0x344 (read-only, bits 3/7/11), mcountinhibit 0x320 (bits 0, 2, 3..3+NUM_HPM-1 writable; bit1 0), mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82, mhpmcounterN/h 0xB00+N/0xB80+N, cycle/cycleh/instret/instreth 0xC00/0xC80/0xC02/0xC82 read-only shadows.
- Write value = mrw(opcode_i, current, din_i); applied only when csr_en_i & csr_we_i & !illegal_o.
- illegal_o = csr_en_i & (address unimplemented | (csr_we_i & addr_i[11:10]==2'b11)); dout_o = 0 when illegal.
- mtvec: MODE bit1 always 0; bit0 writable only if VECTORED_EN; base bits[1:0] excluded from target.
- trap_pc_o = base if MODE=0 or mcause_i[MXLEN-1]=0; else base + 4*mcause_i[4:0].
- Trap: mepc <= pc_i & ~3, mcause <= mcause_i, mtval <= mtval_i, MPIE <= MIE, MIE <= 0.
- mret: MIE <= MPIE, MPIE <= 1.
- Priority per register: trap_i > mret_i > CSR write. Simultaneous trap_i and mret_i: trap only.
- mip bits register irq_i each cycle (1-cycle delay). irq_req_o = MIE & |(mip & mie). Priority external(11) > software(3) > timer(7); irq_cause_o = {1'b1, code}; 0 when none.
- Counters 64-bit, wrap 2^64-1 -> 0. mcycle +1 per cycle, minstret +1 on instret_i, hpmN +1 on hpm_event_i, each unless its inhibit bit set. CSR write to either half replaces that half; the other half takes its normal increment result (carry from written low half is not propagated that cycle).
- Reset: all CSRs 0 except mtvec = MTVEC_RESET (MODE masked per VECTORED_EN), MPP = 2'b11; outputs: irq_req_o 0, irq_cause_o 0, mepc_o 0, trap_pc_o = MTVEC_RESET base.

## Timing
- Reads, illegal_o, trap_pc_o, irq_req_o, irq_cause_o combinational from registered state and current inputs.
- Writes, trap and mret effects visible on the cycle after the edge; same-cycle read returns old value.
- irq_i to irq_req_o: 1 cycle; mie/MIE write to irq_req_o: 1 cycle.
- Reset assertion mid-operation clears state immediately, independent of clk_i.

## Test plan
- Reset then read mstatus/mtvec/mcycle -> 0x1800 / MTVEC_RESET / small cycle count increasing by 1 per read cycle.
- mtvec write 0x8000_0001, trap mcause_i 0x8000_0007 -> trap_pc_o 0x8000_001C (VECTORED_EN=1); 0x8000_0000 with VECTORED_EN=0.
- MIE=1, trap pc_i 0x104 -> mepc 0x104, MIE 0, MPIE 1; mret -> MIE 1, MPIE 1; trap+mret same cycle -> trap only.
- mie=0x888, MIE=1, irq_i=3'b111 -> irq_req_o 1 next cycle, irq_cause_o 0x8000_000B; drop external -> 0x8000_0003.
- mcycle written 0xFFFF_FFFF, mcycleh 0 -> next read mcycleh 1; mcountinhibit bit0 set -> mcycle frozen.
- Write to 0xC00 or read 0x7C0 -> illegal_o 1, dout_o 0, no CSR changes.
